// File: rtl/velocity_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : velocity_tick_gen
//  Purpose  : Source side of the delivery game's velocity selection.
//             - Seven free-running tick generators produce one-cycle strobes
//               v0 (slowest) .. v6 (fastest) for velocity_mux to choose from.
//             - sel_player: player speed code, stepped by rising edges of the
//               debounced speed_up / speed_down buttons, saturating 0..3.
//             - sel_base: game level code, advanced every DELIV_PER_LEVEL
//               deliveries, saturating at 3, with a level_up pulse per step.
//  Ports    :
//    clock       in   1  system clock
//    reset       in   1  asynchronous, active-high reset
//    clear       in   1  synchronous game restart (same effect as reset)
//    enable      in   1  1 = tick counters run, 0 = counters hold, no ticks
//    speed_up    in   1  debounced level, player speed increase request
//    speed_down  in   1  debounced level, player speed decrease request
//    delivered   in   1  one-cycle pulse per completed delivery
//    v0..v6      out  1  registered tick strobes
//    sel_base    out  2  level code
//    sel_player  out  2  player speed code
//    level_up    out  1  one-cycle pulse when sel_base increments
//  Revision : 1.0  initial release
// ============================================================================
module velocity_tick_gen #(
    parameter int PERIOD0         = 50_000_000,
    parameter int PERIOD1         = 40_000_000,
    parameter int PERIOD2         = 30_000_000,
    parameter int PERIOD3         = 20_000_000,
    parameter int PERIOD4         = 12_500_000,
    parameter int PERIOD5         = 8_000_000,
    parameter int PERIOD6         = 5_000_000,
    parameter int DELIV_PER_LEVEL = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic       speed_up,
    input  logic       speed_down,
    input  logic       delivered,
    output logic       v0,
    output logic       v1,
    output logic       v2,
    output logic       v3,
    output logic       v4,
    output logic       v5,
    output logic       v6,
    output logic [1:0] sel_base,
    output logic [1:0] sel_player,
    output logic       level_up
);

    // ------------------------------------------------------------------------
    // Tick generators
    // ------------------------------------------------------------------------
    // Maps a generator index to its period so the counters can be built in a
    // single generate loop.
    function automatic int period_of(input int idx);
        case (idx)
            0:       return PERIOD0;
            1:       return PERIOD1;
            2:       return PERIOD2;
            3:       return PERIOD3;
            4:       return PERIOD4;
            5:       return PERIOD5;
            default: return PERIOD6;
        endcase
    endfunction

    logic [6:0] w_tick;

    generate
        for (genvar k = 0; k < 7; k++) begin : g_tick
            localparam int c_period = period_of(k);
            localparam int c_cnt_w  = $clog2(c_period);
            localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_period - 1);

            logic [c_cnt_w-1:0] r_cnt;
            logic               r_tick;

            // The strobe is registered off the terminal count, so it appears
            // in the cycle after the counter sits at PERIOD-1. While paused
            // the count is frozen, which preserves phase across the pause.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_cnt  <= '0;
                    r_tick <= 1'b0;
                end else if (clear) begin
                    r_cnt  <= '0;
                    r_tick <= 1'b0;
                end else if (enable) begin
                    if (r_cnt == c_last) begin
                        r_cnt  <= '0;
                        r_tick <= 1'b1;
                    end else begin
                        r_cnt  <= r_cnt + c_cnt_w'(1);
                        r_tick <= 1'b0;
                    end
                end else begin
                    r_tick <= 1'b0;
                end
            end

            assign w_tick[k] = r_tick;
        end
    endgenerate

    assign v0 = w_tick[0];
    assign v1 = w_tick[1];
    assign v2 = w_tick[2];
    assign v3 = w_tick[3];
    assign v4 = w_tick[4];
    assign v5 = w_tick[5];
    assign v6 = w_tick[6];

    // ------------------------------------------------------------------------
    // Player speed select
    // ------------------------------------------------------------------------
    logic       r_up_prev;
    logic       r_dn_prev;
    logic [1:0] r_sel_player;
    logic       w_up_edge;
    logic       w_dn_edge;

    assign w_up_edge = speed_up & ~r_up_prev;
    assign w_dn_edge = speed_down & ~r_dn_prev;

    // Simultaneous up and down edges cancel; held levels produce no edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_up_prev    <= 1'b0;
            r_dn_prev    <= 1'b0;
            r_sel_player <= 2'd0;
        end else if (clear) begin
            r_up_prev    <= 1'b0;
            r_dn_prev    <= 1'b0;
            r_sel_player <= 2'd0;
        end else begin
            r_up_prev <= speed_up;
            r_dn_prev <= speed_down;
            if (w_up_edge && !w_dn_edge && (r_sel_player != 2'd3)) begin
                r_sel_player <= r_sel_player + 2'd1;
            end else if (w_dn_edge && !w_up_edge && (r_sel_player != 2'd0)) begin
                r_sel_player <= r_sel_player - 2'd1;
            end
        end
    end

    assign sel_player = r_sel_player;

    // ------------------------------------------------------------------------
    // Level select
    // ------------------------------------------------------------------------
    // A single-delivery level still needs a one-bit counter to stay legal.
    localparam int c_deliv_w = (DELIV_PER_LEVEL > 1) ? $clog2(DELIV_PER_LEVEL) : 1;
    localparam logic [c_deliv_w-1:0] c_deliv_last = c_deliv_w'(DELIV_PER_LEVEL - 1);

    logic [c_deliv_w-1:0] r_deliv_cnt;
    logic [1:0]           r_sel_base;
    logic                 r_level_up;

    // The delivery counter keeps wrapping at the top level so the count
    // stays bounded; only the select and pulse saturate.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_deliv_cnt <= '0;
            r_sel_base  <= 2'd0;
            r_level_up  <= 1'b0;
        end else if (clear) begin
            r_deliv_cnt <= '0;
            r_sel_base  <= 2'd0;
            r_level_up  <= 1'b0;
        end else begin
            r_level_up <= 1'b0;
            if (delivered) begin
                if (r_deliv_cnt == c_deliv_last) begin
                    r_deliv_cnt <= '0;
                    if (r_sel_base != 2'd3) begin
                        r_sel_base <= r_sel_base + 2'd1;
                        r_level_up <= 1'b1;
                    end
                end else begin
                    r_deliv_cnt <= r_deliv_cnt + c_deliv_w'(1);
                end
            end
        end
    end

    assign sel_base = r_sel_base;
    assign level_up = r_level_up;

endmodule
`default_nettype wire

// File: tb/tb_velocity_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_velocity_tick_gen
//  Purpose  : Self-checking bench for velocity_tick_gen with short periods.
//  Revision : 1.0  initial release
// ============================================================================
module tb_velocity_tick_gen;

    localparam int DPL = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       clear;
    logic       enable;
    logic       speed_up;
    logic       speed_down;
    logic       delivered;
    logic       v0, v1, v2, v3, v4, v5, v6;
    logic [1:0] sel_base;
    logic [1:0] sel_player;
    logic       level_up;
    logic [6:0] ticks;

    assign ticks = {v6, v5, v4, v3, v2, v1, v0};

    velocity_tick_gen #(
        .PERIOD0(8), .PERIOD1(7), .PERIOD2(6), .PERIOD3(5),
        .PERIOD4(4), .PERIOD5(3), .PERIOD6(2),
        .DELIV_PER_LEVEL(DPL)
    ) dut (
        .clock(clock), .reset(reset), .clear(clear), .enable(enable),
        .speed_up(speed_up), .speed_down(speed_down), .delivered(delivered),
        .v0(v0), .v1(v1), .v2(v2), .v3(v3), .v4(v4), .v5(v5), .v6(v6),
        .sel_base(sel_base), .sel_player(sel_player), .level_up(level_up)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int periods[7];

    // Reference model: abstract counts, not counters.
    int         m_en_cycles;   // enabled, non-clear edges since reset/clear
    int         m_deliv;       // deliveries since reset/clear
    int         m_sp;
    bit         m_pu, m_pd;
    logic [6:0] m_v;
    int         m_base;
    bit         m_lu;

    typedef struct {
        bit clr, up, dn, dl;
        int sp, sb;
        bit lu;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_en_cycles = 0; m_deliv = 0; m_sp = 0;
        m_pu = 0; m_pd = 0; m_v = '0; m_base = 0; m_lu = 0;
    endtask

    task automatic model_edge();
        bit ue, de;
        if (clear) begin
            model_reset();
        end else begin
            if (enable) begin
                m_en_cycles++;
                for (int k = 0; k < 7; k++) m_v[k] = (m_en_cycles % periods[k] == 0);
            end else begin
                m_v = '0;
            end
            ue = speed_up && !m_pu;
            de = speed_down && !m_pd;
            if (ue && !de && m_sp < 3) m_sp++;
            if (de && !ue && m_sp > 0) m_sp--;
            m_pu = speed_up;
            m_pd = speed_down;
            m_lu = 0;
            if (delivered) begin
                m_deliv++;
                if (m_deliv % DPL == 0 && m_deliv / DPL <= 3) m_lu = 1;
            end
            m_base = (m_deliv / DPL > 3) ? 3 : m_deliv / DPL;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " ticks"}, ticks, m_v);
        check({tag, " sel_player"}, sel_player, m_sp);
        check({tag, " sel_base"}, sel_base, m_base);
        check({tag, " level_up"}, level_up, m_lu);
    endtask

    task automatic set_in(input bit c, input bit e, input bit u, input bit d, input bit dl);
        clear = c; enable = e; speed_up = u; speed_down = d; delivered = dl;
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " ticks"}, ticks, 0);
        check({tag, " sel_player"}, sel_player, 0);
        check({tag, " sel_base"}, sel_base, 0);
        check({tag, " level_up"}, level_up, 0);
    endtask

    task automatic add(input bit c, input bit u, input bit d, input bit dl,
                       input int sp, input int sb, input bit lu);
        vec_t v;
        v.clr = c; v.up = u; v.dn = d; v.dl = dl; v.sp = sp; v.sb = sb; v.lu = lu;
        vecs.push_back(v);
    endtask

    initial begin
        int base_exp[8];
        bit lu_exp[8];
        periods = '{8, 7, 6, 5, 4, 3, 2};
        base_exp = '{0, 1, 1, 2, 2, 3, 3, 3};
        lu_exp   = '{0, 1, 0, 1, 0, 1, 0, 0};

        // ---------------- Power-on reset ----------------
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_zero("por");
        @(negedge clock);
        reset = 1'b0;

        // ---------------- Reset mid-count, then first-tick timing ----------------
        set_in(0, 1, 0, 0, 0);
        for (int t = 0; t < 5; t++) step("precount");
        reset = 1'b1;
        #2;
        model_reset();
        check_zero("async_reset");
        @(negedge clock);
        reset = 1'b0;
        for (int t = 1; t <= 20; t++) begin
            step("run");
            check("v6 cadence", v6, (t % 2 == 0));
            check("v0 cadence", v0, (t % 8 == 0));
        end

        // ---------------- Pause for 5 cycles starting at cycle 3 ----------------
        set_in(1, 1, 0, 0, 0);
        step("clear_pre_pause");
        set_in(0, 1, 0, 0, 0);
        for (int t = 1; t <= 24; t++) begin
            enable = !(t >= 3 && t <= 7);
            step("pause");
            if (t >= 3 && t <= 7) check("no tick in pause", ticks, 0);
            check("v0 delayed", v0, (t == 13 || t == 21));
        end

        // ---------------- Table-driven select/level vectors ----------------
        set_in(1, 1, 0, 0, 0);
        step("clear_pre_table");
        for (int i = 0; i < 4; i++) begin
            add(0, 1, 0, 0, (i + 1 > 3) ? 3 : i + 1, 0, 0);
            add(0, 0, 0, 0, (i + 1 > 3) ? 3 : i + 1, 0, 0);
        end
        add(0, 1, 1, 0, 3, 0, 0);
        add(0, 0, 0, 0, 3, 0, 0);
        for (int i = 0; i < 10; i++) add(0, 0, 1, 0, 2, 0, 0);
        add(0, 0, 0, 0, 2, 0, 0);
        for (int i = 0; i < 8; i++) begin
            add(0, 0, 0, 1, 2, base_exp[i], lu_exp[i]);
            add(0, 0, 0, 0, 2, base_exp[i], 0);
        end
        add(1, 1, 0, 1, 0, 0, 0);   // clear wins over delivery and up edge
        add(0, 1, 0, 0, 1, 0, 0);   // edge register was cleared, so edge again
        add(0, 0, 0, 0, 1, 0, 0);
        foreach (vecs[i]) begin
            set_in(vecs[i].clr, 1, vecs[i].up, vecs[i].dn, vecs[i].dl);
            step("table");
            check($sformatf("vec%0d sel_player", i), sel_player, vecs[i].sp);
            check($sformatf("vec%0d sel_base", i), sel_base, vecs[i].sb);
            check($sformatf("vec%0d level_up", i), level_up, vecs[i].lu);
            if (vecs[i].clr) check($sformatf("vec%0d ticks", i), ticks, 0);
        end

        // ---------------- Randomized run against the model ----------------
        for (int t = 0; t < 260; t++) begin
            set_in($urandom_range(0, 79) == 0, $urandom_range(0, 9) != 0,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 3) == 0);
            step("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
